// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: serialises wide DMA beats into 16-bit link words and
// wraps them in K-code delimited frames with header, number, length and checksum.
module tlk2711_tx_framer #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned SYNC_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES  = 256,
  parameter int unsigned BODY_WORDS  = 435
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_soft_reset,
  input  logic                  i_tx_start,
  input  logic                  i_tx_stop,
  input  logic [15:0]           i_last_frame,
  input  logic [15:0]           i_tail_bytes,
  input  logic                  i_s_valid,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  output logic                  o_s_ready,
  output logic                  o_busy,
  output logic                  o_tx_done,
  output logic                  o_underflow,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_2711_tkmsb,
  output logic                  o_2711_tklsb,
  output logic [15:0]           o_2711_txd
);

  localparam int unsigned   HW        = DATA_WIDTH / 16;
  localparam int unsigned   IW        = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(HW - 1);
  localparam logic [31:0]   SYNC_LAST = 32'(SYNC_CYCLES - 1);
  localparam logic [31:0]   GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]   BODY_LAST = 32'(BODY_WORDS - 1);
  localparam logic [15:0]   BODY_LEN  = 16'(BODY_WORDS * 2);

  localparam logic [3:0] S_IDLE  = 4'd0,  S_SYNC  = 4'd1,  S_SOF  = 4'd2,
                         S_HEAD0 = 4'd3,  S_HEAD1 = 4'd4,  S_SIGN = 4'd5,
                         S_FNUM  = 4'd6,  S_DLEN  = 4'd7,  S_DATA = 4'd8,
                         S_CHK   = 4'd9,  S_EOF   = 4'd10, S_GAP  = 4'd11;

  logic [3:0]            state, state_n;
  logic [31:0]           cnt, cnt_n;
  logic [DATA_WIDTH-1:0] beat;
  logic                  full;
  logic [IW-1:0]         idx;
  logic [15:0]           chk, last_q, tail_q, hw_word, data_word;
  logic [17:0]           word_n;
  logic                  stop_pend, stop_now, to_idle, frame_inc;
  logic                  is_final, idx_last, accept, consume;

  always_comb begin
    hw_word = '0;
    for (int unsigned i = 0; i < HW; i++)
      if (idx == IW'(i)) hw_word = beat[i*16 +: 16];
  end

  assign idx_last  = (idx == IDX_LAST);
  assign data_word = full ? hw_word : '0;
  assign is_final  = (o_frame_cnt == last_q);
  assign stop_now  = stop_pend | i_tx_stop;
  assign o_s_ready = o_busy & (~full | ((state == S_DATA) & idx_last));
  assign accept    = i_s_valid & o_s_ready;
  assign consume   = (state == S_DATA) & full;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    to_idle   = 1'b0;
    frame_inc = 1'b0;
    case (state)
      S_IDLE:  if (i_tx_start) begin state_n = S_SYNC; cnt_n = '0; end
      S_SYNC: begin
        if (stop_now) begin
          state_n = S_IDLE;
          to_idle = 1'b1;
        end else if (cnt == SYNC_LAST) begin
          state_n = S_SOF;
          cnt_n   = '0;
        end else cnt_n = cnt + 32'd1;
      end
      S_SOF:   state_n = S_HEAD0;
      S_HEAD0: state_n = S_HEAD1;
      S_HEAD1: state_n = S_SIGN;
      S_SIGN:  state_n = S_FNUM;
      S_FNUM:  state_n = S_DLEN;
      S_DLEN:  begin state_n = S_DATA; cnt_n = '0; end
      S_DATA: begin
        if (cnt == BODY_LAST) state_n = S_CHK;
        else cnt_n = cnt + 32'd1;
      end
      S_CHK:   state_n = S_EOF;
      S_EOF:   begin state_n = S_GAP; cnt_n = '0; end
      S_GAP: begin
        if (cnt != GAP_LAST) cnt_n = cnt + 32'd1;
        else if (is_final | stop_now) begin
          state_n = S_IDLE;
          to_idle = 1'b1;
        end else begin
          state_n   = S_SOF;
          frame_inc = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Link word for the current state, registered onto the pins next cycle.
  always_comb begin
    word_n = '0;
    case (state)
      S_SYNC, S_GAP: word_n = {2'b01, 16'hC5BC};
      S_SOF:   word_n = {2'b11, 16'h5CFB};
      S_HEAD0: word_n = {2'b00, 16'hE116};
      S_HEAD1: word_n = {2'b00, 16'hEB90};
      S_SIGN:  word_n = {2'b00, is_final ? 16'h0181 : 16'h0081};
      S_FNUM:  word_n = {2'b00, o_frame_cnt};
      S_DLEN:  word_n = {2'b00, is_final ? tail_q : BODY_LEN};
      S_DATA:  word_n = {2'b00, data_word};
      S_CHK:   word_n = {2'b00, chk};
      S_EOF:   word_n = {2'b11, 16'hFDFE};
      default: word_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst | i_soft_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      beat        <= '0;
      full        <= 1'b0;
      idx         <= '0;
      chk         <= '0;
      last_q      <= '0;
      tail_q      <= '0;
      stop_pend   <= 1'b0;
      o_busy      <= 1'b0;
      o_tx_done   <= 1'b0;
      o_underflow <= 1'b0;
      o_frame_cnt <= '0;
      {o_2711_tkmsb, o_2711_tklsb, o_2711_txd} <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_busy    <= (state_n != S_IDLE);
      o_tx_done <= to_idle;
      {o_2711_tkmsb, o_2711_tklsb, o_2711_txd} <= word_n;

      if ((state == S_IDLE) && i_tx_start) begin
        last_q      <= i_last_frame;
        tail_q      <= i_tail_bytes;
        o_frame_cnt <= '0;
        o_underflow <= 1'b0;
      end else begin
        if (frame_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
        if ((state == S_DATA) && !full) o_underflow <= 1'b1;
      end

      if (state_n == S_IDLE) stop_pend <= 1'b0;
      else if ((state != S_IDLE) && i_tx_stop) stop_pend <= 1'b1;

      // A beat accepted on the last half-word refills the gearbox in the same cycle.
      if (consume) begin
        if (idx_last) begin
          full <= 1'b0;
          idx  <= '0;
        end else idx <= idx + IW'(1);
      end
      if (accept) begin
        beat <= i_s_data;
        full <= 1'b1;
        idx  <= '0;
      end

      if (state == S_SOF) chk <= '0;
      else if (state == S_DATA) chk <= chk + data_word;
    end
  end

endmodule
